// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. It counts pixel positions and
//   produces sync, active and frame/line strobes for the mode set by the
//   parameters. A pixel clock enable gates all progress. A PIPE_DLY-deep
//   delay line provides retimed copies of sync/active for downstream
//   pipelines.
//
// Ports
//   clk          in   pixel clock
//   reset        in   asynchronous, active-low reset
//   ce           in   pixel enable; state advances only when ce=1
//   x, y         out  [15:0] current pixel position
//   hsync, vsync out  sync levels for (x,y), polarity set by HS_POL/VS_POL
//   active       out  1 inside the visible window
//   line_start   out  one-clk strobe, x became 0
//   frame_start  out  one-clk strobe, (x,y) became (0,0)
//   hsync_d, vsync_d, active_d
//                out  hsync/vsync/active delayed PIPE_DLY ce-cycles
// ---------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int PIPE_DLY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic        line_start,
   output logic        frame_start,
   output logic        hsync_d,
   output logic        vsync_d,
   output logic        active_d
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Window bounds are 17 bits wide so that a 65536-wide total never overflows.
   localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
   localparam logic [16:0] H_ACT    = 17'(H_ACTIVE);
   localparam logic [16:0] V_ACT    = 17'(V_ACTIVE);
   localparam logic [16:0] HS_START = 17'(H_ACTIVE + H_FP);
   localparam logic [16:0] HS_END   = 17'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [16:0] VS_START = 17'(V_ACTIVE + V_FP);
   localparam logic [16:0] VS_END   = 17'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic HS_ON  = (HS_POL != 0) ? 1'b1 : 1'b0;
   localparam logic VS_ON  = (VS_POL != 0) ? 1'b1 : 1'b0;
   localparam logic HS_OFF = ~HS_ON;
   localparam logic VS_OFF = ~VS_ON;

   if ((H_TOTAL > 65536) || (V_TOTAL > 65536) ||
       (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
       (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) ||
       (PIPE_DLY < 0) || (PIPE_DLY > 15)) begin : g_bad_param
      $error("video_timing_gen: illegal timing parameter set");
   end

   // True when lo <= v < hi.
   function automatic logic in_window(input logic [15:0] v,
                                      input logic [16:0] lo,
                                      input logic [16:0] hi);
      return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
   endfunction

   // Internal position, primed to the last pixel so the first ce lands on (0,0).
   logic [15:0] pos_x_r;
   logic [15:0] pos_y_r;

   logic [15:0] nx_s;
   logic [15:0] ny_s;
   logic        hsync_s;
   logic        vsync_s;
   logic        active_s;

   // Next raster position; y advances only on the horizontal wrap.
   always_comb begin
      nx_s = pos_x_r;
      ny_s = pos_y_r;
      if (pos_x_r == H_LAST) begin
         nx_s = 16'd0;
         if (pos_y_r == V_LAST) begin
            ny_s = 16'd0;
         end else begin
            ny_s = pos_y_r + 16'd1;
         end
      end else begin
         nx_s = pos_x_r + 16'd1;
         ny_s = pos_y_r;
      end
   end

   // Decode sync/active from the next position so they register alongside x/y.
   always_comb begin
      hsync_s  = in_window(nx_s, HS_START, HS_END) ? HS_ON : HS_OFF;
      vsync_s  = in_window(ny_s, VS_START, VS_END) ? VS_ON : VS_OFF;
      active_s = ({1'b0, nx_s} < H_ACT) && ({1'b0, ny_s} < V_ACT);
   end

   // Position counter and registered timing outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_x_r     <= H_LAST;
         pos_y_r     <= V_LAST;
         x           <= 16'd0;
         y           <= 16'd0;
         hsync       <= HS_OFF;
         vsync       <= VS_OFF;
         active      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (ce) begin
         pos_x_r     <= nx_s;
         pos_y_r     <= ny_s;
         x           <= nx_s;
         y           <= ny_s;
         hsync       <= hsync_s;
         vsync       <= vsync_s;
         active      <= active_s;
         line_start  <= (nx_s == 16'd0);
         frame_start <= (nx_s == 16'd0) && (ny_s == 16'd0);
      end else begin
         // Strobes last a single clk even when ce drops right after them.
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

   if (PIPE_DLY == 0) begin : g_no_dly
      assign hsync_d  = hsync;
      assign vsync_d  = vsync;
      assign active_d = active;
   end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_sr_r;
      logic [PIPE_DLY-1:0] vs_sr_r;
      logic [PIPE_DLY-1:0] act_sr_r;

      // Shift register fed from the registered outputs, so the last stage
      // holds the value from exactly PIPE_DLY ce-cycles earlier.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            hs_sr_r  <= {PIPE_DLY{HS_OFF}};
            vs_sr_r  <= {PIPE_DLY{VS_OFF}};
            act_sr_r <= {PIPE_DLY{1'b0}};
         end else if (ce) begin
            hs_sr_r[0]  <= hsync;
            vs_sr_r[0]  <= vsync;
            act_sr_r[0] <= active;
            for (int i = 1; i < PIPE_DLY; i++) begin
               hs_sr_r[i]  <= hs_sr_r[i-1];
               vs_sr_r[i]  <= vs_sr_r[i-1];
               act_sr_r[i] <= act_sr_r[i-1];
            end
         end else begin
            hs_sr_r  <= hs_sr_r;
            vs_sr_r  <= vs_sr_r;
            act_sr_r <= act_sr_r;
         end
      end

      assign hsync_d  = hs_sr_r[PIPE_DLY-1];
      assign vsync_d  = vs_sr_r[PIPE_DLY-1];
      assign active_d = act_sr_r[PIPE_DLY-1];
   end

endmodule
